vga_timing_checker: RTL and testbench

//  Receive-side counterpart of the 640x480 VGA timing generator: samples VGA_CLK/HS/VS/BLANK_n
//  on clk50 and recovers the pixel enable and pixel column/row. Measures line and frame geometry,

---
 rtl/vga_timing_checker_if.sv | 30 +++
 rtl/vga_timing_checker.sv | 173 +++++++++++++++++
 tb/tb_vga_timing_checker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_checker_if.sv
// VGA receive-side bundle: sampled sync/blank inputs plus the recovered pixel and status outputs.
// The master drives the video signals; the slave is the timing checker.
interface vga_timing_checker_if;
  logic        vga_clk;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        pix_valid;
  logic [9:0]  pix_col;
  logic [9:0]  pix_row;
  logic        line_start;
  logic        frame_start;
  logic        locked;
  logic [10:0] meas_htotal;
  logic [9:0]  meas_vtotal;
  logic        err_pulse;
  logic [7:0]  err_count;

  modport master (
    output vga_clk, vga_hs, vga_vs, vga_blank_n,
    input  pix_valid, pix_col, pix_row, line_start, frame_start, locked,
    input  meas_htotal, meas_vtotal, err_pulse, err_count
  );

  modport slave (
    input  vga_clk, vga_hs, vga_vs, vga_blank_n,
    output pix_valid, pix_col, pix_row, line_start, frame_start, locked,
    output meas_htotal, meas_vtotal, err_pulse, err_count
  );
endinterface

// File: rtl/vga_timing_checker.sv
// Samples a VGA pixel stream on clk50, measures line/frame geometry, locks after clean frames
// and emits pixel coordinates plus timing-error pulses.
module vga_timing_checker #(
  parameter int EXP_HTOTAL  = 800,
  parameter int EXP_HACTIVE = 640,
  parameter int EXP_VTOTAL  = 525,
  parameter int EXP_VACTIVE = 480,
  parameter int LOCK_FRAMES = 2
) (
  input logic clk50,
  input logic reset_n,
  vga_timing_checker_if.slave vid
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [10:0] H_TOT  = 11'(EXP_HTOTAL);
  localparam logic [10:0] H_ACT  = 11'(EXP_HACTIVE);
  localparam logic [9:0]  V_TOT  = 10'(EXP_VTOTAL);
  localparam logic [9:0]  V_ACT  = 10'(EXP_VACTIVE);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  logic        vclk_reg, vclk_dly_reg, hs_reg, vs_reg, blank_reg;
  logic        hs_prev_reg, vs_prev_reg, blank_prev_reg;
  logic        hs_seen_reg, vs_seen_reg, row_first_reg, frame_err_reg;
  logic [10:0] hlen_reg, hact_reg;
  logic [9:0]  vlen_reg, vact_reg, col_reg, row_reg;
  logic [3:0]  good_reg;
  state_t      state_reg;

  logic pe, hs_fall, vs_fall, blank_rise, blank_fall;
  logic hsat_err, htot_err, hact_err, vtot_err, vact_err, any_err, frame_err_now, pix_now;
  logic [9:0] col_next, row_next;

  always_comb begin
    pe         = vclk_reg & ~vclk_dly_reg;
    hs_fall    = pe & hs_prev_reg & ~hs_reg;
    vs_fall    = pe & vs_prev_reg & ~vs_reg;
    blank_rise = pe & ~blank_prev_reg & blank_reg;
    blank_fall = pe & blank_prev_reg & ~blank_reg;
    // Saturation fires once, on the pe that takes hlen from 2046 to 2047.
    hsat_err   = pe & ~hs_fall & (hlen_reg == 11'd2046);
    htot_err   = hs_fall & hs_seen_reg & (hlen_reg != H_TOT);
    hact_err   = blank_fall & hs_seen_reg & (hact_reg != H_ACT);
    vtot_err   = vs_fall & vs_seen_reg & (vlen_reg != V_TOT);
    vact_err   = vs_fall & vs_seen_reg & (vact_reg != V_ACT);
    any_err    = hsat_err | htot_err | hact_err | vtot_err | vact_err;
    frame_err_now = frame_err_reg | any_err;
    pix_now    = pe & blank_reg & (state_reg == LOCKED);

    col_next = col_reg;
    if (blank_rise)
      col_next = 10'd0;
    else if (blank_reg && col_reg != 10'h3FF)
      col_next = col_reg + 10'd1;

    row_next = row_reg;
    if (blank_rise) begin
      if (row_first_reg | vs_fall)
        row_next = 10'd0;
      else if (row_reg != 10'h3FF)
        row_next = row_reg + 10'd1;
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      vclk_reg <= 1'b0; vclk_dly_reg <= 1'b0;
      hs_reg <= 1'b0; vs_reg <= 1'b0; blank_reg <= 1'b0;
      hs_prev_reg <= 1'b0; vs_prev_reg <= 1'b0; blank_prev_reg <= 1'b0;
      hs_seen_reg <= 1'b0; vs_seen_reg <= 1'b0; row_first_reg <= 1'b0; frame_err_reg <= 1'b0;
      hlen_reg <= '0; hact_reg <= '0; vlen_reg <= '0; vact_reg <= '0;
      col_reg <= '0; row_reg <= '0; good_reg <= '0;
      state_reg <= SEARCH;
      vid.pix_valid <= 1'b0; vid.pix_col <= '0; vid.pix_row <= '0;
      vid.line_start <= 1'b0; vid.frame_start <= 1'b0; vid.locked <= 1'b0;
      vid.meas_htotal <= '0; vid.meas_vtotal <= '0;
      vid.err_pulse <= 1'b0; vid.err_count <= '0;
    end else begin
      vclk_reg     <= vid.vga_clk;
      vclk_dly_reg <= vclk_reg;
      hs_reg       <= vid.vga_hs;
      vs_reg       <= vid.vga_vs;
      blank_reg    <= vid.vga_blank_n;

      vid.pix_valid   <= pix_now;
      vid.line_start  <= pix_now & (col_next == 10'd0);
      vid.frame_start <= pix_now & (col_next == 10'd0) & (row_next == 10'd0);
      vid.err_pulse   <= any_err;

      if (pe) begin
        hs_prev_reg    <= hs_reg;
        vs_prev_reg    <= vs_reg;
        blank_prev_reg <= blank_reg;

        if (hs_fall) begin
          vid.meas_htotal <= hlen_reg;
          hlen_reg        <= 11'd1;
          hs_seen_reg     <= 1'b1;
        end else if (hlen_reg != 11'h7FF) begin
          hlen_reg <= hlen_reg + 11'd1;
        end

        // An HS fall coincident with VS fall belongs to the new frame.
        if (vs_fall) begin
          vid.meas_vtotal <= vlen_reg;
          vlen_reg        <= {9'd0, hs_fall};
          vact_reg        <= {9'd0, blank_rise};
          vs_seen_reg     <= 1'b1;
        end else begin
          if (hs_fall && vlen_reg != 10'h3FF)
            vlen_reg <= vlen_reg + 10'd1;
          if (blank_rise && vact_reg != 10'h3FF)
            vact_reg <= vact_reg + 10'd1;
        end

        if (blank_fall)
          hact_reg <= '0;
        else if (blank_reg && hact_reg != 11'h7FF)
          hact_reg <= hact_reg + 11'd1;

        col_reg <= col_next;
        row_reg <= row_next;
        if (blank_rise)
          row_first_reg <= 1'b0;
        else if (vs_fall)
          row_first_reg <= 1'b1;

        if (any_err && vid.err_count != 8'hFF)
          vid.err_count <= vid.err_count + 8'd1;
        frame_err_reg <= vs_fall ? 1'b0 : frame_err_now;

        if (pix_now) begin
          vid.pix_col <= col_next;
          vid.pix_row <= row_next;
        end

        case (state_reg)
          SEARCH: begin
            if (vs_fall) begin
              state_reg <= MEASURE;
              good_reg  <= '0;
            end
          end
          MEASURE: begin
            if (vs_fall) begin
              if (frame_err_now) begin
                good_reg <= '0;
              end else begin
                good_reg <= good_reg + 4'd1;
                if (good_reg + 4'd1 == LOCK_N) begin
                  state_reg  <= LOCKED;
                  vid.locked <= 1'b1;
                end
              end
            end
          end
          LOCKED: begin
            if (hsat_err) begin
              state_reg  <= SEARCH;
              good_reg   <= '0;
              vid.locked <= 1'b0;
            end else if (any_err) begin
              state_reg  <= MEASURE;
              good_reg   <= '0;
              vid.locked <= 1'b0;
            end
          end
          default: state_reg <= SEARCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_checker.sv
// Bench for vga_timing_checker on a scaled-down raster (40x20 total, 32x12 active, 2 clk50 per pixel).
module tb_vga_timing_checker;
  localparam int HTOT = 40, HACT = 32, HS_BEG = 34, HS_END = 38;
  localparam int VTOT = 20, VACT = 12, VS_BEG = 14, VS_END = 16;
  localparam int PM_IGNORE = 0, PM_EXPECT = 1, PM_FORBID = 2;

  typedef logic [21:0] pix_t;  // {col, row, line_start, frame_start}

  logic clk50 = 1'b0;
  logic reset_n = 1'b0;
  vga_timing_checker_if vid();

  vga_timing_checker #(
    .EXP_HTOTAL(HTOT), .EXP_HACTIVE(HACT), .EXP_VTOTAL(VTOT), .EXP_VACTIVE(VACT), .LOCK_FRAMES(2)
  ) dut (
    .clk50(clk50),
    .reset_n(reset_n),
    .vid(vid)
  );

  always #10 clk50 = ~clk50;

  int errors = 0, checks = 0;
  int cyc = 0, vs_fall_cyc = 0, lock_rise_cyc = 0;
  int pix_cnt = 0, ls_cnt = 0, fs_cnt = 0, errp_cnt = 0;
  int pix_mode = PM_FORBID;
  logic [10:0] err_htot = '0;
  logic last_vs = 1'b1;
  logic locked_d = 1'b0;
  pix_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk50);
    cyc++;
  end

  // Output monitor: pops the scoreboard on every pixel and tallies pulses.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk50);
      if (vid.locked === 1'b1 && locked_d !== 1'b1) lock_rise_cyc = cyc;
      locked_d = vid.locked;
      if (vid.err_pulse === 1'b1) begin
        errp_cnt++;
        err_htot = vid.meas_htotal;
      end
      if (vid.line_start === 1'b1) ls_cnt++;
      if (vid.frame_start === 1'b1) fs_cnt++;
      if (vid.pix_valid === 1'b1) begin
        pix_cnt++;
        if (pix_mode == PM_FORBID) begin
          check("pix_forbidden", 32'(vid.pix_valid), 0);
        end else if (pix_mode == PM_EXPECT) begin
          if (exp_q.size() == 0) begin
            check("pix_unexpected", 32'(vid.pix_valid), 0);
          end else begin
            e = exp_q.pop_front();
            check("pix", 32'({vid.pix_col, vid.pix_row, vid.line_start, vid.frame_start}), 32'(e));
            $display("pix col=%0d row=%0d ls=%0b fs=%0b", vid.pix_col, vid.pix_row,
                     vid.line_start, vid.frame_start);
          end
        end
      end
    end
  end

  task automatic drive_px(input logic hs, input logic vs, input logic blank,
                          input logic [9:0] c, input logic [9:0] r, input bit push);
    @(negedge clk50);
    vid.vga_clk = 1'b0;
    vid.vga_hs = hs;
    vid.vga_vs = vs;
    vid.vga_blank_n = blank;
    @(negedge clk50);
    vid.vga_clk = 1'b1;
    if (!vs && last_vs) vs_fall_cyc = cyc;
    last_vs = vs;
    if (push) exp_q.push_back({c, r, c == 10'd0, (c == 10'd0) && (r == 10'd0)});
  endtask

  task automatic run_line(input int v, input int htot);
    bit act;
    for (int h = 0; h < htot; h++) begin
      act = (h < HACT) && (v < VACT);
      drive_px(!(h >= HS_BEG && h < HS_END), !(v >= VS_BEG && v < VS_END), act,
               10'(h), 10'(v), act && (pix_mode == PM_EXPECT));
    end
  endtask

  task automatic run_frame(input int bad_first, input int bad_num);
    for (int v = 0; v < VTOT; v++)
      run_line(v, (v >= bad_first && v < bad_first + bad_num) ? HTOT + 1 : HTOT);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk50);
  endtask

  task automatic acquire_lock(input string tag);
    pix_mode = PM_FORBID;
    errp_cnt = 0;
    lock_rise_cyc = 0;
    run_frame(0, 0);
    check({tag, "_meas_htotal"}, 32'(vid.meas_htotal), HTOT);
    check({tag, "_locked_f1"}, 32'(vid.locked), 0);
    run_frame(0, 0);
    check({tag, "_locked_f2"}, 32'(vid.locked), 0);
    check({tag, "_meas_vtotal"}, 32'(vid.meas_vtotal), VTOT);
    run_frame(0, 0);
    settle();
    check({tag, "_locked_f3"}, 32'(vid.locked), 1);
    check({tag, "_lock_latency"}, 32'(lock_rise_cyc - vs_fall_cyc), 2);
    check({tag, "_err_count"}, 32'(vid.err_count), 0);
    check({tag, "_err_pulses"}, 32'(errp_cnt), 0);
    $display("%s: locked=%0b htotal=%0d vtotal=%0d", tag, vid.locked, vid.meas_htotal, vid.meas_vtotal);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vid.vga_clk = 1'b0;
    vid.vga_hs = 1'b1;
    vid.vga_vs = 1'b1;
    vid.vga_blank_n = 1'b0;
    repeat (3) @(negedge clk50);
    check("reset_pix", 32'({vid.pix_valid, vid.pix_col, vid.pix_row, vid.line_start,
                            vid.frame_start, vid.locked, vid.err_pulse}), 0);
    check("reset_meas", 32'({vid.meas_htotal, vid.meas_vtotal, vid.err_count}), 0);
    reset_n = 1'b1;

    // Nominal timing: lock one cycle after the third VS fall.
    acquire_lock("t1");

    // One fully locked frame against the scoreboard.
    pix_mode = PM_EXPECT;
    pix_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    run_frame(0, 0);
    settle();
    check("t2_pix_count", 32'(pix_cnt), HACT * VACT);
    check("t2_line_starts", 32'(ls_cnt), VACT);
    check("t2_frame_starts", 32'(fs_cnt), 1);
    check("t2_queue_left", 32'(exp_q.size()), 0);
    $display("t2: pixels=%0d line_starts=%0d", pix_cnt, ls_cnt);

    // One stretched line, then relock on the second clean VS fall.
    pix_mode = PM_IGNORE;
    errp_cnt = 0;
    run_frame(5, 1);
    settle();
    check("t3_err_pulses", 32'(errp_cnt), 1);
    check("t3_err_count", 32'(vid.err_count), 1);
    check("t3_meas_at_err", 32'(err_htot), HTOT + 1);
    check("t3_locked", 32'(vid.locked), 0);
    pix_mode = PM_FORBID;
    run_frame(0, 0);
    check("t3_locked_clean1", 32'(vid.locked), 0);
    run_frame(0, 0);
    settle();
    check("t3_relocked", 32'(vid.locked), 1);
    $display("t3: err_count=%0d relocked=%0b", vid.err_count, vid.locked);

    // HS stuck high: hlen saturation drops lock.
    errp_cnt = 0;
    for (int i = 0; i < 2100; i++) drive_px(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
    settle();
    check("t4_sat_pulses", 32'(errp_cnt), 1);
    check("t4_locked", 32'(vid.locked), 0);
    run_line(0, HTOT);
    settle();
    check("t4_meas_sat", 32'(vid.meas_htotal), 2047);
    for (int v = 1; v < VTOT; v++) run_line(v, HTOT);
    run_frame(0, 0);
    check("t4_locked_r2", 32'(vid.locked), 0);
    run_frame(0, 0);
    settle();
    check("t4_relocked", 32'(vid.locked), 1);
    $display("t4: meas_htotal=%0d locked=%0b", vid.meas_htotal, vid.locked);

    // Asynchronous reset mid-frame while locked.
    pix_mode = PM_IGNORE;
    for (int v = 0; v < 6; v++) run_line(v, HTOT);
    @(posedge clk50);
    #3;
    reset_n = 1'b0;
    #1;
    check("t5_rst_pix", 32'({vid.pix_valid, vid.pix_col, vid.pix_row, vid.line_start,
                             vid.frame_start, vid.locked, vid.err_pulse}), 0);
    check("t5_rst_meas", 32'({vid.meas_htotal, vid.meas_vtotal, vid.err_count}), 0);
    @(negedge clk50);
    vid.vga_clk = 1'b0;
    last_vs = 1'b1;
    repeat (3) @(negedge clk50);
    reset_n = 1'b1;
    acquire_lock("t5");

    // 300 bad lines: counter saturates, pulses keep firing.
    pix_mode = PM_IGNORE;
    errp_cnt = 0;
    for (int f = 0; f < 15; f++) run_frame(0, VTOT);
    settle();
    check("t6_pulses_mid", 32'(errp_cnt), 299);
    check("t6_err_count_mid", 32'(vid.err_count), 255);
    run_frame(0, 0);
    settle();
    check("t6_pulses", 32'(errp_cnt), 300);
    check("t6_err_count", 32'(vid.err_count), 255);
    $display("t6: err_pulses=%0d err_count=%0d", errp_cnt, vid.err_count);

    // Stalled pixel clock: sync lines wiggle but nothing may move.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk50);
      vid.vga_hs = 1'($urandom);
      vid.vga_vs = 1'($urandom);
      vid.vga_blank_n = 1'($urandom);
    end
    settle();
    check("stall_pulses", 32'(errp_cnt), 300);
    check("stall_meas", 32'({vid.meas_htotal, vid.meas_vtotal}), 32'({11'(HTOT), 10'(VTOT)}));
    check("stall_err_count", 32'(vid.err_count), 255);
    $display("stall: err_count=%0d htotal=%0d", vid.err_count, vid.meas_htotal);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
